// File: rtl/shift_ctrl.sv
// Operand-2 shift sequencer: maps ARM shift encodings onto the barrel shifter,
// fetches Rs for register-specified shifts and returns a registered result.

// Combinational barrel shifter with ARM carry-out semantics.
module shift_unit (
  input  logic [31:0] op,
  input  logic [2:0]  kind,
  input  logic [7:0]  amount,
  input  logic        cin,
  output logic [31:0] result,
  output logic        cout
);
  localparam int unsigned DW = 32;

  localparam logic [2:0] KIND_LSL = 3'd0;
  localparam logic [2:0] KIND_LSR = 3'd1;
  localparam logic [2:0] KIND_ASR = 3'd2;
  localparam logic [2:0] KIND_ROR = 3'd3;
  localparam logic [2:0] KIND_RRX = 3'd4;

  logic [DW:0]   lsl_w;
  logic [DW:0]   lsr_w;
  logic [DW:0]   asr_w;
  logic [4:0]    rot;
  logic [DW-1:0] ror_w;

  // One extra bit beside the operand captures the last bit shifted out;
  // amounts of 32 and above fall out of the shift naturally.
  always_comb begin
    lsl_w  = {1'b0, op} << amount;
    lsr_w  = {op, 1'b0} >> amount;
    asr_w  = (DW+1)'($signed({op, 1'b0}) >>> amount);
    rot    = amount[4:0];
    ror_w  = (op >> rot) | (op << (6'd32 - 6'(rot)));
    result = op;
    cout   = cin;
    case (kind)
      KIND_LSL: begin result = lsl_w[DW-1:0]; cout = lsl_w[DW]; end
      KIND_LSR: begin result = lsr_w[DW:1];   cout = lsr_w[0];  end
      KIND_ASR: begin result = asr_w[DW:1];   cout = asr_w[0];  end
      KIND_ROR: begin result = ror_w;         cout = ror_w[DW-1]; end
      KIND_RRX: begin result = {cin, op[DW-1:1]}; cout = op[0]; end
      default:  begin result = op;            cout = cin;       end
    endcase
  end
endmodule

module shift_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_op,
  input  logic [1:0]  i_shift_code,
  input  logic        i_reg_shift,
  input  logic [4:0]  i_imm,
  input  logic [3:0]  i_rs_addr,
  input  logic        i_carry,
  output logic        o_rf_req,
  output logic [3:0]  o_rf_addr,
  input  logic        i_rf_ack,
  input  logic [31:0] i_rf_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_carry,
  output logic        o_busy
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  localparam logic [2:0] KIND_LSR    = 3'd1;
  localparam logic [2:0] KIND_ASR    = 3'd2;
  localparam logic [2:0] KIND_RRX    = 3'd4;
  localparam logic [2:0] KIND_BYPASS = 3'd7;
  localparam logic [1:0] CODE_LSL    = 2'd0;
  localparam logic [1:0] CODE_LSR    = 2'd1;
  localparam logic [1:0] CODE_ASR    = 2'd2;
  localparam logic [1:0] CODE_ROR    = 2'd3;

  typedef enum logic [1:0] {IDLE, RF_WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          accept, load_res, latch_req, use_latched;
  logic [DW-1:0] op_q;
  logic [1:0]    code_q;
  logic          carry_q;
  logic [DW-1:0] src_op;
  logic [1:0]    src_code;
  logic          src_c;
  logic [2:0]    sh_kind;
  logic [AW-1:0] sh_amt;
  logic          ror_fix;
  logic [DW-1:0] sh_result;
  logic          sh_cout;
  logic [DW-1:0] next_result;
  logic          next_carry;
  logic          unused_rf_bits;

  assign unused_rf_bits = ^i_rf_data[DW-1:AW];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, handshake and load enables.
  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    accept      = 1'b0;
    load_res    = 1'b0;
    latch_req   = 1'b0;
    use_latched = 1'b0;
    o_ready = !i_flush && ((state_q == IDLE) || ((state_q == DONE) && i_ready));
    accept  = i_valid && o_ready;
    if (i_flush) begin
      state_d = IDLE;
    end else if (accept) begin
      if (i_reg_shift) begin
        state_d   = RF_WAIT;
        latch_req = 1'b1;
      end else begin
        state_d  = DONE;
        load_res = 1'b1;
      end
    end else begin
      case (state_q)
        RF_WAIT: begin
          if (i_rf_ack) begin
            state_d     = DONE;
            load_res    = 1'b1;
            use_latched = 1'b1;
          end
        end
        DONE:    if (i_ready) state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Map the encoding's special cases onto shifter type/amount.
  always_comb begin
    src_op   = use_latched ? op_q    : i_op;
    src_code = use_latched ? code_q  : i_shift_code;
    src_c    = use_latched ? carry_q : i_carry;
    sh_kind  = {1'b0, src_code};
    sh_amt   = '0;
    ror_fix  = 1'b0;
    if (use_latched) begin
      sh_amt = i_rf_data[AW-1:0];
      if (sh_amt == '0) begin
        sh_kind = KIND_BYPASS;
      end else if ((src_code == CODE_ROR) && (sh_amt[4:0] == 5'd0)) begin
        ror_fix = 1'b1;
      end
    end else begin
      sh_amt = AW'(i_imm);
      if (i_imm == 5'd0) begin
        case (src_code)
          CODE_LSL: sh_kind = KIND_BYPASS;
          CODE_LSR: begin sh_kind = KIND_LSR; sh_amt = AW'(32); end
          CODE_ASR: begin sh_kind = KIND_ASR; sh_amt = AW'(32); end
          default:  sh_kind = KIND_RRX;
        endcase
      end
    end
    next_result = ror_fix ? src_op : sh_result;
    next_carry  = ror_fix ? src_op[DW-1] : sh_cout;
  end

  shift_unit u_shift (
    .op     (src_op),
    .kind   (sh_kind),
    .amount (sh_amt),
    .cin    (src_c),
    .result (sh_result),
    .cout   (sh_cout)
  );

  // Request latch, status flags and the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_rf_req  <= 1'b0;
      o_busy    <= 1'b0;
      o_rf_addr <= '0;
      o_result  <= '0;
      o_carry   <= 1'b0;
      op_q      <= '0;
      code_q    <= '0;
      carry_q   <= 1'b0;
    end else begin
      o_valid  <= (state_d == DONE);
      o_rf_req <= (state_d == RF_WAIT);
      o_busy   <= (state_d != IDLE);
      if (latch_req) begin
        op_q      <= i_op;
        code_q    <= i_shift_code;
        carry_q   <= i_carry;
        o_rf_addr <= i_rs_addr;
      end
      if (load_res) begin
        o_result <= next_result;
        o_carry  <= next_carry;
      end
    end
  end
endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl against a bit-serial ARM shifter model.
module tb_shift_ctrl;
  logic        i_clk, i_rst, i_flush, i_valid, o_ready;
  logic [31:0] i_op;
  logic [1:0]  i_shift_code;
  logic        i_reg_shift;
  logic [4:0]  i_imm;
  logic [3:0]  i_rs_addr;
  logic        i_carry, o_rf_req;
  logic [3:0]  o_rf_addr;
  logic        i_rf_ack;
  logic [31:0] i_rf_data;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic        o_carry, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_op(i_op), .i_shift_code(i_shift_code),
    .i_reg_shift(i_reg_shift), .i_imm(i_imm), .i_rs_addr(i_rs_addr),
    .i_carry(i_carry), .o_rf_req(o_rf_req), .o_rf_addr(o_rf_addr),
    .i_rf_ack(i_rf_ack), .i_rf_data(i_rf_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_carry(o_carry), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: shift one bit at a time, carry is the last bit shifted out.
  function automatic logic [32:0] ref_shift(input logic [31:0] op, input logic [1:0] code,
                                            input logic is_reg, input logic [7:0] amt,
                                            input logic c);
    logic [31:0] r;
    logic        cy;
    int          n;
    r  = op;
    cy = c;
    n  = int'(amt);
    if (!is_reg && amt == 8'd0) begin
      if (code == 2'd0) return {c, op};
      if (code == 2'd3) return {op[0], c, op[31:1]};
      n = 32;
    end
    for (int i = 0; i < n; i++) begin
      case (code)
        2'd0:    begin cy = r[31]; r = {r[30:0], 1'b0}; end
        2'd1:    begin cy = r[0];  r = {1'b0, r[31:1]}; end
        2'd2:    begin cy = r[0];  r = {r[31], r[31:1]}; end
        default: begin cy = r[0];  r = {r[0], r[31:1]}; end
      endcase
    end
    return {cy, r};
  endfunction

  task automatic drive_imm(input logic [31:0] op, input logic [1:0] code,
                           input logic [4:0] imm, input logic c);
    i_valid = 1'b1; i_reg_shift = 1'b0; i_op = op; i_shift_code = code;
    i_imm = imm; i_carry = c; i_rs_addr = 4'($urandom);
  endtask

  // Runs one register-shift transaction with the ack after 'delay' request cycles.
  task automatic run_reg(input logic [31:0] op, input logic [1:0] code, input logic [3:0] rs,
                         input logic c, input logic [31:0] rsval, input int delay,
                         output int req_cnt, output logic bad_side,
                         output logic [32:0] got, output logic vld, output logic req_after);
    i_valid = 1'b1; i_reg_shift = 1'b1; i_op = op; i_shift_code = code;
    i_imm = 5'($urandom); i_carry = c; i_rs_addr = rs; i_ready = 1'b0; i_rf_ack = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0; i_op = $urandom; i_shift_code = 2'($urandom); i_carry = ~c;
    i_rs_addr = 4'($urandom);
    req_cnt = 0; bad_side = 1'b0;
    for (int k = 1; k <= delay; k++) begin
      if (o_rf_req) req_cnt++;
      if (o_rf_addr !== rs || o_valid !== 1'b0 || o_busy !== 1'b1) bad_side = 1'b1;
      i_rf_ack  = (k == delay);
      i_rf_data = (k == delay) ? rsval : $urandom;
      @(negedge i_clk);
    end
    i_rf_ack = 1'b0; i_rf_data = $urandom;
    got = {o_carry, o_result}; vld = o_valid; req_after = o_rf_req;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_op = '0; i_shift_code = '0;
    i_reg_shift = 1'b0; i_imm = '0; i_rs_addr = '0; i_carry = 1'b0; i_rf_ack = 1'b0;
    i_rf_data = '0; i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    n_checks++;
    if ({o_valid, o_rf_req, o_busy, o_carry} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got v/req/busy/c=%b exp 0000", {o_valid, o_rf_req, o_busy, o_carry});
    end
    n_checks++;
    if (o_result !== 32'h0 || o_rf_addr !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: got result=%h addr=%h exp 0/0", o_result, o_rf_addr);
    end
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
  endtask

  task automatic test_imm_directed;
    logic [31:0] ops [5]  = '{32'h8000000F, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001};
    logic [1:0]  codes[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [4:0]  imms [5] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    logic        cs   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [32:0] exps [5] = '{{1'b0, 32'h000000F0}, {1'b1, 32'h00000000}, {1'b1, 32'hFFFFFFFF},
                              {1'b1, 32'hC0000000}, {1'b1, 32'h80000001}};
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_imm(ops[i], codes[i], imms[i], cs[i]);
      @(negedge i_clk);
      i_valid = 1'b0;
      n_checks++;
      if (o_valid !== 1'b1 || {o_carry, o_result} !== exps[i]) begin
        n_fail++; $display("FAIL imm_special[%0d]: got v=%b c/res=%h exp v=1 %h", i, o_valid, {o_carry, o_result}, exps[i]);
      end
      @(negedge i_clk);
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL imm_retire: got v=%b busy=%b exp 0/0", o_valid, o_busy);
    end
  endtask

  task automatic test_imm_stream;
    logic [32:0] exp_q[$];
    logic [31:0] op;
    logic [1:0]  code;
    logic [4:0]  imm;
    logic        c;
    i_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() != 0) begin
        n_checks++;
        if (o_valid !== 1'b1 || {o_carry, o_result} !== exp_q[0]) begin
          n_fail++; $display("FAIL imm_stream[%0d]: got v=%b c/res=%h exp v=1 %h", i, o_valid, {o_carry, o_result}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      op = $urandom; code = 2'($urandom); c = 1'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive_imm(op, code, imm, c);
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL imm_stream_ready[%0d]: got %b exp 1", i, o_ready); end
      exp_q.push_back(ref_shift(op, code, 1'b0, 8'(imm), c));
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== exp_q[0]) begin
      n_fail++; $display("FAIL imm_stream_last: got v=%b c/res=%h exp v=1 %h", o_valid, {o_carry, o_result}, exp_q[0]);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reg_directed;
    int cnt; logic bad, vld, req_after; logic [32:0] got;
    run_reg(32'h80000000, 2'd3, 4'd9, 1'b0, 32'h00000020, 3, cnt, bad, got, vld, req_after);
    n_checks++;
    if (cnt != 3 || bad !== 1'b0) begin
      n_fail++; $display("FAIL reg_ror_req: got req_cycles=%0d side_err=%b exp 3/0", cnt, bad);
    end
    n_checks++;
    if (vld !== 1'b1 || got !== {1'b1, 32'h80000000} || req_after !== 1'b0) begin
      n_fail++; $display("FAIL reg_ror_result: got v=%b c/res=%h req=%b exp 1 180000000 0", vld, got, req_after);
    end
    run_reg(32'hFFFFFFFF, 2'd0, 4'd3, 1'b1, 32'hABCDEF00, 1, cnt, bad, got, vld, req_after);
    n_checks++;
    if (vld !== 1'b1 || got !== {1'b1, 32'hFFFFFFFF} || cnt != 1) begin
      n_fail++; $display("FAIL reg_lsl_0: got v=%b c/res=%h req=%0d exp 1 1ffffffff 1", vld, got, cnt);
    end
    run_reg(32'hFFFFFFFF, 2'd0, 4'd3, 1'b1, 32'h00000021, 1, cnt, bad, got, vld, req_after);
    n_checks++;
    if (vld !== 1'b1 || got !== 33'h0) begin
      n_fail++; $display("FAIL reg_lsl_33: got v=%b c/res=%h exp 1 000000000", vld, got);
    end
  endtask

  task automatic test_reg_random;
    int cnt, delay; logic bad, vld, req_after; logic [32:0] got, exp;
    logic [31:0] op, rsval; logic [1:0] code; logic c; logic [3:0] rs;
    for (int i = 0; i < 30; i++) begin
      op = $urandom; code = 2'($urandom); c = 1'($urandom); rs = 4'($urandom);
      rsval = $urandom & 32'hFFFFFF00;
      case ($urandom_range(0, 4))
        0:       rsval[7:0] = 8'd0;
        1:       rsval[7:0] = {3'($urandom_range(1, 7)), 5'd0};
        2:       rsval[7:0] = 8'($urandom_range(1, 31));
        3:       rsval[7:0] = 8'($urandom_range(33, 255));
        default: rsval[7:0] = 8'($urandom);
      endcase
      delay = $urandom_range(1, 4);
      run_reg(op, code, rs, c, rsval, delay, cnt, bad, got, vld, req_after);
      exp = ref_shift(op, code, 1'b1, rsval[7:0], c);
      n_checks++;
      if (vld !== 1'b1 || got !== exp || cnt != delay || bad !== 1'b0 || req_after !== 1'b0) begin
        n_fail++; $display("FAIL reg_rand[%0d]: code=%0d amt=%0d got v=%b c/res=%h req=%0d side=%b exp %h req=%0d",
                           i, code, rsval[7:0], vld, got, cnt, bad, exp, delay);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp;
    i_ready = 1'b1;
    drive_imm(32'h0000_00F0, 2'd1, 5'd4, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b1; i_reg_shift = 1'b1; i_op = 32'h1234_5678; i_shift_code = 2'd3;
    i_rs_addr = 4'd6; i_carry = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== 33'h0_0000_000F || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got v=%b c/res=%h rdy=%b exp 1 00000000f 1", o_valid, {o_carry, o_result}, o_ready);
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_rf_req !== 1'b1 || o_rf_addr !== 4'd6) begin
      n_fail++; $display("FAIL b2b_rf: got v=%b req=%b addr=%h exp 0 1 6", o_valid, o_rf_req, o_rf_addr);
    end
    i_rf_ack = 1'b1; i_rf_data = 32'h0000_0008;
    @(negedge i_clk);
    i_rf_ack = 1'b0;
    exp = ref_shift(32'h1234_5678, 2'd3, 1'b1, 8'd8, 1'b0);
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== exp) begin
      n_fail++; $display("FAIL b2b_second: got v=%b c/res=%h exp 1 %h", o_valid, {o_carry, o_result}, exp);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] ops[3]; logic [4:0] imms[3]; logic [32:0] exps[3];
    for (int i = 0; i < 3; i++) begin
      ops[i] = $urandom; imms[i] = 5'($urandom_range(1, 31));
      exps[i] = ref_shift(ops[i], 2'd2, 1'b0, 8'(imms[i]), 1'b0);
    end
    i_ready = 1'b1;
    drive_imm(ops[0], 2'd2, imms[0], 1'b0);
    @(negedge i_clk);
    i_ready = 1'b0;
    drive_imm(ops[1], 2'd2, imms[1], 1'b0);
    for (int s = 0; s < 3; s++) begin
      if (s == 2) i_ready = 1'b1;
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || {o_carry, o_result} !== exps[0] || o_ready !== (s == 2)) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got v=%b c/res=%h rdy=%b exp 1 %h %b", s, o_valid, {o_carry, o_result}, o_ready, exps[0], s == 2);
      end
      @(negedge i_clk);
    end
    drive_imm(ops[2], 2'd2, imms[2], 1'b0);
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== exps[1]) begin
      n_fail++; $display("FAIL bp_second: got v=%b c/res=%h exp 1 %h", o_valid, {o_carry, o_result}, exps[1]);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== exps[2]) begin
      n_fail++; $display("FAIL bp_third: got v=%b c/res=%h exp 1 %h", o_valid, {o_carry, o_result}, exps[2]);
    end
    @(negedge i_clk);
  endtask

  task automatic test_flush_reset;
    i_ready = 1'b0;
    i_valid = 1'b1; i_reg_shift = 1'b1; i_op = 32'hDEAD_BEEF; i_shift_code = 2'd0;
    i_rs_addr = 4'hA; i_carry = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_flush = 1'b1; i_rf_ack = 1'b1; i_rf_data = 32'h4;
    drive_imm(32'h1, 2'd0, 5'd1, 1'b0);
    #1;
    n_checks++;
    if (o_ready !== 1'b0 || o_rf_req !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got rdy=%b req=%b exp 0 1", o_ready, o_rf_req);
    end
    @(negedge i_clk);
    i_flush = 1'b0; i_rf_ack = 1'b0; i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_rf_req, o_busy} !== 3'b000) begin
      n_fail++; $display("FAIL flush_idle: got v/req/busy=%b exp 000", {o_valid, o_rf_req, o_busy});
    end
    i_rf_ack = 1'b1;
    @(negedge i_clk);
    i_rf_ack = 1'b0;
    n_checks++;
    if ({o_valid, o_rf_req, o_busy} !== 3'b000) begin
      n_fail++; $display("FAIL stray_ack: got v/req/busy=%b exp 000", {o_valid, o_rf_req, o_busy});
    end
    drive_imm(32'h9234_5678, 2'd0, 5'd1, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_done: got v=%b busy=%b exp 0 0", o_valid, o_busy);
    end
    drive_imm(32'h9234_5678, 2'd0, 5'd1, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || {o_carry, o_result} !== {1'b1, 32'h2468ACF0} || o_rf_addr !== 4'hA) begin
      n_fail++; $display("FAIL pre_reset: got v=%b c/res=%h addr=%h exp 1 12468acf0 a", o_valid, {o_carry, o_result}, o_rf_addr);
    end
    i_rst = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_flush = 1'b0;
    n_checks++;
    if ({o_valid, o_rf_req, o_busy, o_carry} !== 4'b0 || o_result !== 32'h0 || o_rf_addr !== 4'h0) begin
      n_fail++; $display("FAIL mid_reset: got v/req/busy/c=%b res=%h addr=%h exp 0000 0 0",
                         {o_valid, o_rf_req, o_busy, o_carry}, o_result, o_rf_addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_imm_directed;
    test_imm_stream;
    test_reg_directed;
    test_reg_random;
    test_back_to_back;
    test_backpressure;
    test_flush_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
